// File: rtl/sa_job_controller.sv
// Job sequencer for one systolic-array matrix-vector pass: clear the array,
// stream K operand words from the SRAMs, drain the pipeline, hand off results.
module sa_job_controller #(
    parameter int NUM_ROW       = 8,
    parameter int IN_WORD_SIZE  = 32,
    parameter int OUT_WORD_SIZE = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int DRAIN_CYCLES  = 2 * NUM_ROW
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ADDR_WIDTH-1:0]              vec_len,
    output logic                               busy,
    output logic                               done,
    output logic [OUT_WORD_SIZE-1:0]           job_cycles,
    output logic                               act_rd_en,
    output logic [ADDR_WIDTH-1:0]              act_rd_addr,
    input  logic [NUM_ROW*IN_WORD_SIZE-1:0]    act_rd_data,
    output logic                               wgt_rd_en,
    output logic [ADDR_WIDTH-1:0]              wgt_rd_addr,
    input  logic [IN_WORD_SIZE-1:0]            wgt_rd_data,
    output logic                               sa_rst,
    output logic [IN_WORD_SIZE-1:0]            sa_top,
    output logic [NUM_ROW*IN_WORD_SIZE-1:0]    sa_left,
    input  logic [NUM_ROW*OUT_WORD_SIZE-1:0]   sa_result,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [NUM_ROW*OUT_WORD_SIZE-1:0]   result_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0]         DRN_LAST  = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRN_W-1:0]         DRN_ONE   = DRN_W'(1);
    localparam logic [DRN_W-1:0]         DRN_ZERO  = DRN_W'(0);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [OUT_WORD_SIZE-1:0] CYC_ONE   = OUT_WORD_SIZE'(1);
    localparam logic [OUT_WORD_SIZE-1:0] CYC_ZERO  = OUT_WORD_SIZE'(0);

    logic [2:0]                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]              base_q, base_d;
    logic [ADDR_WIDTH-1:0]              len_q, len_d;
    logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]              issue_q, issue_d;
    logic [DRN_W-1:0]                   drain_q, drain_d;
    logic                               rd_en_q, rd_en_d;
    logic                               feed_valid_q, feed_valid_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               result_valid_q, result_valid_d;
    logic [NUM_ROW*OUT_WORD_SIZE-1:0]   result_data_q, result_data_d;
    logic [OUT_WORD_SIZE-1:0]           job_cycles_q, job_cycles_d;

    // Next-state and datapath update for the job sequencer
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        addr_d        = addr_q;
        issue_d       = issue_q;
        drain_d       = drain_q;
        result_data_d = result_data_q;

        if (busy_q) begin
            job_cycles_d = job_cycles_q + CYC_ONE;
        end else begin
            job_cycles_d = job_cycles_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    job_cycles_d = CYC_ZERO;
                    // A zero-length job skips the array and SRAMs entirely.
                    if (vec_len != ADDR_ZERO) begin
                        base_d  = base_addr;
                        len_d   = vec_len;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                addr_d  = base_q;
                issue_d = ADDR_ZERO;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (issue_q == len_q - ADDR_ONE) begin
                    drain_d = DRN_LAST;
                    state_d = S_DRAIN;
                end else begin
                    issue_d = issue_q + ADDR_ONE;
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_FEED;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRN_ZERO) begin
                    result_data_d = sa_result;
                    state_d       = S_OUTPUT;
                end else begin
                    drain_d = drain_q - DRN_ONE;
                    state_d = S_DRAIN;
                end
            end
            S_OUTPUT: begin
                if (result_ready) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        result_valid_d = (state_d == S_OUTPUT);
        rd_en_d        = (state_d == S_FEED);
        feed_valid_d   = rd_en_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            base_q         <= ADDR_ZERO;
            len_q          <= ADDR_ZERO;
            addr_q         <= ADDR_ZERO;
            issue_q        <= ADDR_ZERO;
            drain_q        <= DRN_ZERO;
            rd_en_q        <= 1'b0;
            feed_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            job_cycles_q   <= CYC_ZERO;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            len_q          <= len_d;
            addr_q         <= addr_d;
            issue_q        <= issue_d;
            drain_q        <= drain_d;
            rd_en_q        <= rd_en_d;
            feed_valid_q   <= feed_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            job_cycles_q   <= job_cycles_d;
        end
    end

    // Operands pass straight from SRAM to array only in the cycle after a read.
    assign sa_left      = feed_valid_q ? act_rd_data : '0;
    assign sa_top       = feed_valid_q ? wgt_rd_data : '0;
    assign sa_rst       = rst | (state_q == S_CLEAR);

    assign busy         = busy_q;
    assign done         = done_q;
    assign job_cycles   = job_cycles_q;
    assign act_rd_en    = rd_en_q;
    assign wgt_rd_en    = rd_en_q;
    assign act_rd_addr  = addr_q;
    assign wgt_rd_addr  = addr_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;

endmodule

// File: tb/tb_sa_job_controller.sv
// Randomized scoreboard bench for sa_job_controller with SRAM and array models.
module tb_sa_job_controller;

    localparam int NR = 8;
    localparam int IW = 32;
    localparam int OW = 32;
    localparam int AW = 10;
    localparam int D  = 2 * NR;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               start;
    logic [AW-1:0]      base_addr;
    logic [AW-1:0]      vec_len;
    logic               busy;
    logic               done;
    logic [OW-1:0]      job_cycles;
    logic               act_rd_en;
    logic [AW-1:0]      act_rd_addr;
    logic [NR*IW-1:0]   act_rd_data;
    logic               wgt_rd_en;
    logic [AW-1:0]      wgt_rd_addr;
    logic [IW-1:0]      wgt_rd_data;
    logic               sa_rst;
    logic [IW-1:0]      sa_top;
    logic [NR*IW-1:0]   sa_left;
    logic [NR*OW-1:0]   sa_result;
    logic               result_valid;
    logic               result_ready;
    logic [NR*OW-1:0]   result_data;

    sa_job_controller #(
        .NUM_ROW(NR), .IN_WORD_SIZE(IW), .OUT_WORD_SIZE(OW),
        .ADDR_WIDTH(AW), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .vec_len(vec_len),
        .busy(busy), .done(done), .job_cycles(job_cycles),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .sa_rst(sa_rst), .sa_top(sa_top), .sa_left(sa_left), .sa_result(sa_result),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data)
    );

    // Operand memories; reads return garbage when not enabled so stray feeds show up.
    logic [NR*IW-1:0] act_mem [0:DEPTH-1];
    logic [IW-1:0]    wgt_mem [0:DEPTH-1];

    always @(posedge clk) begin
        for (int r = 0; r < NR; r++)
            act_rd_data[r*IW +: IW] <= act_rd_en ? act_mem[act_rd_addr][r*IW +: IW] : $urandom;
        wgt_rd_data <= wgt_rd_en ? wgt_mem[wgt_rd_addr] : $urandom;
    end

    // Behavioural array: each row accumulates left*top every cycle.
    logic [OW-1:0] acc [NR];
    always @(posedge clk) begin
        for (int r = 0; r < NR; r++)
            acc[r] <= sa_rst ? '0 : acc[r] + sa_left[r*IW +: IW] * sa_top;
    end
    always_comb begin
        sa_result = '0;
        for (int r = 0; r < NR; r++) sa_result[r*OW +: OW] = acc[r];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int k; int bp; int start_cyc; logic [NR*OW-1:0] res; } job_t;
    typedef struct { int addr; int cyc; } rd_t;
    job_t exp_q[$];
    rd_t  rd_q[$];
    int   clr_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [NR*OW-1:0] act, input logic [NR*OW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference result: dot product of the operand window, per row.
    function automatic logic [NR*OW-1:0] ref_result(input int k, input int base);
        logic [NR*OW-1:0] res;
        logic [OW-1:0]    s;
        int               a;
        res = '0;
        for (int r = 0; r < NR; r++) begin
            s = '0;
            for (int n = 0; n < k; n++) begin
                a = (base + n) % DEPTH;
                s = s + act_mem[a][r*IW +: IW] * wgt_mem[a];
            end
            res[r*OW +: OW] = s;
        end
        return res;
    endfunction

    // Monitor: pops expectations whenever the DUT reads, clears, hands off or finishes.
    rd_t              re;
    job_t             je;
    int               nexp;
    int               jc_exp = -1;
    bit               hold_v = 1'b0;
    logic [NR*OW-1:0] hold_d;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("sa_rst_in_reset", sa_rst, 1);
                hold_v = 1'b0;
                jc_exp = -1;
            end else begin
                if (jc_exp >= 0) begin
                    chk("job_cycles", job_cycles, jc_exp);
                    jc_exp = -1;
                end
                if (act_rd_en || wgt_rd_en) begin
                    if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
                    else begin
                        re = rd_q.pop_front();
                        chk("act_rd_addr", act_rd_addr, re.addr);
                        chk("wgt_rd_addr", wgt_rd_addr, re.addr);
                        chk("rd_en_pair", act_rd_en & wgt_rd_en, 1);
                        chk("rd_cycle", cyc, re.cyc);
                    end
                end
                if (sa_rst) begin
                    if (clr_q.size() == 0) chk("unexpected_sa_rst", 1, 0);
                    else chk("sa_rst_cycle", cyc, clr_q.pop_front());
                end
                if (hold_v) begin
                    chk("valid_held", result_valid, 1);
                    chkw("data_held", result_data, hold_d);
                end
                hold_v = 1'b0;
                if (result_valid) begin
                    if (exp_q.size() == 0 || exp_q[0].k == 0) chk("unexpected_valid", 1, 0);
                    else if (result_ready) begin
                        chkw("result_data", result_data, exp_q[0].res);
                        chk("handshake_cycle", cyc,
                            exp_q[0].start_cyc + exp_q[0].k + 2 + D + exp_q[0].bp);
                    end else begin
                        hold_v = 1'b1;
                        hold_d = result_data;
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        je   = exp_q.pop_front();
                        nexp = (je.k == 0) ? 1 : je.k + 3 + D + je.bp;
                        chk("done_cycle", cyc, je.start_cyc + nexp);
                        chk("busy_at_done", busy, 1);
                        jc_exp = nexp;
                    end
                end
            end
        end
    end

    // Issue one job starting in the current cycle; return in the cycle after done.
    task automatic run_job(input int k, input int base, input int bp, input bit glitch);
        job_t j;
        rd_t  rr;
        int   c, endc;
        c = cyc;
        j.k = k; j.bp = bp; j.start_cyc = c; j.res = ref_result(k, base);
        exp_q.push_back(j);
        if (k != 0) begin
            clr_q.push_back(c + 1);
            for (int n = 0; n < k; n++) begin
                rr.addr = (base + n) % DEPTH;
                rr.cyc  = c + 2 + n;
                rd_q.push_back(rr);
            end
            result_ready = (bp == 0);
        end
        start = 1'b1; base_addr = AW'(base); vec_len = AW'(k);
        endc = (k == 0) ? c + 1 : c + k + 3 + D + bp;
        while (cyc < endc + 1) begin
            @(posedge clk); #1;
            start     = glitch && (cyc == c + 3 || cyc == c + 10);
            base_addr = AW'($urandom);
            vec_len   = AW'($urandom_range(1, DEPTH - 1));
            if (k != 0) result_ready = (bp == 0) || (cyc >= c + k + 2 + D + bp);
        end
    endtask

    task automatic run_reset_mid();
        job_t j;
        rd_t  rr;
        int   c, base;
        c = cyc;
        base = $urandom_range(0, DEPTH - 1);
        j.k = 8; j.bp = 0; j.start_cyc = c; j.res = '0;
        exp_q.push_back(j);
        clr_q.push_back(c + 1);
        for (int n = 0; n < 8; n++) begin
            rr.addr = (base + n) % DEPTH;
            rr.cyc  = c + 2 + n;
            rd_q.push_back(rr);
        end
        start = 1'b1; base_addr = AW'(base); vec_len = AW'(8);
        while (cyc < c + 4) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        exp_q.delete(); rd_q.delete(); clr_q.delete();
        @(posedge clk); #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_valid", result_valid, 0);
        chk("rst_mid_rd_en", act_rd_en, 0);
        chk("rst_mid_job_cycles", job_cycles, 0);
        chk("rst_mid_sa_rst", sa_rst, 1);
        chkw("rst_mid_sa_left", sa_left, '0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            for (int r = 0; r < NR; r++) act_mem[a][r*IW +: IW] = $urandom_range(0, 255);
            wgt_mem[a] = $urandom_range(0, 255);
        end
        for (int n = 0; n < 4; n++) begin
            for (int r = 0; r < NR; r++) act_mem[n][r*IW +: IW] = r + n;
            wgt_mem[n] = 1;
        end

        rst = 1'b1; start = 1'b0; base_addr = '0; vec_len = '0; result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_rd_en", act_rd_en | wgt_rd_en, 0);
        chk("reset_job_cycles", job_cycles, 0);
        chk("reset_sa_rst", sa_rst, 1);
        chk("reset_sa_top", sa_top, 0);
        chkw("reset_sa_left", sa_left, '0);
        chkw("reset_result_data", result_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(4, 0, 0, 1'b0);
        run_job(4, 0, 5, 1'b1);
        run_job(4, 1022, 0, 1'b0);
        run_job(0, 5, 0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        run_reset_mid();
        run_job(6, 1020, 2, 1'b0);

        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 4) == 0)
                run_job(0, $urandom_range(0, DEPTH - 1), 0, 1'b0);
            else
                run_job($urandom_range(1, 12), $urandom_range(0, DEPTH - 1),
                        $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (5) begin @(posedge clk); #1; end
        chk("jobs_outstanding", exp_q.size(), 0);
        chk("reads_outstanding", rd_q.size(), 0);
        chk("clears_outstanding", clr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sa_job_controller.md
# sa_job_controller

Sequencer that runs one matrix-vector job on the systolic array. On a start request it clears the array, streams `vec_len` activation/weight words from the operand buffers into the array's left and top inputs, waits for the array pipeline to drain, and captures the per-row accumulator outputs. It then presents the results over a valid/ready handshake. It sits between the job scheduler and its operand SRAMs on one side and one systolic array instance on the other.

## Interface
- `NUM_ROW`, 8, rows in the attached array
- `IN_WORD_SIZE`, 32, operand word width
- `OUT_WORD_SIZE`, 32, accumulator width per row
- `ADDR_WIDTH`, 10, operand buffer address width; `vec_len` uses the same width
- `DRAIN_CYCLES`, 2*NUM_ROW, cycles waited after the last operand is issued
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: job request; sampled only in IDLE
- `base_addr` in ADDR_WIDTH: first operand address; sampled with `start`
- `vec_len` in ADDR_WIDTH: number of operand words K; sampled with `start`
- `busy` out 1: high from the cycle after an accepted start through the `done` cycle
- `done` out 1: one-cycle pulse at job end
- `job_cycles` out OUT_WORD_SIZE: busy-cycle count of the last job; cleared on each accepted start
- `act_rd_en` out 1, `act_rd_addr` out ADDR_WIDTH, `act_rd_data` in NUM_ROW*IN_WORD_SIZE: activation SRAM port, read latency 1
- `wgt_rd_en` out 1, `wgt_rd_addr` out ADDR_WIDTH, `wgt_rd_data` in IN_WORD_SIZE: weight SRAM port, read latency 1
- `sa_rst` out 1: reset to the array
- `sa_top` out IN_WORD_SIZE: array top input
- `sa_left` out NUM_ROW*IN_WORD_SIZE: array left inputs
- `sa_result` in NUM_ROW*OUT_WORD_SIZE: array per-row outputs
- `result_valid` out 1, `result_ready` in 1, `result_data` out NUM_ROW*OUT_WORD_SIZE: result handshake

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE.
- **IDLE.** On `start`=1:
  - If `vec_len`≠0: latch `base_addr`/`vec_len` and go to CLEAR.
  - If `vec_len`=0: go to DONE. The array and SRAMs are not touched, and `result_valid` never rises.
- **CLEAR.** One cycle with `sa_rst`=1. Then go to FEED.
- **FEED.** K cycles; issue index n=0..K-1.
  - `act_rd_en`=`wgt_rd_en`=1.
  - Both addresses = (base+n) mod 2^ADDR_WIDTH.
  - After issue K-1, go to DRAIN.
- **Operand delivery.** `feed_valid` is `rd_en` delayed one cycle.
  - While `feed_valid`=1: `sa_left`=`act_rd_data` and `sa_top`=`wgt_rd_data`, driven combinationally.
  - Otherwise both are driven to zero, so the array accumulates nothing extra.
- **DRAIN.** DRAIN_CYCLES cycles, down-counter.
  - The first DRAIN cycle carries the last operand (`feed_valid`=1).
  - On the last DRAIN cycle, register `sa_result` into `result_data`. Go to OUTPUT.
- **OUTPUT.** `result_valid`=1 and `result_data` are held stable until `result_ready`=1. On that handshake cycle go to DONE.
- **DONE.** `done`=1 and `busy`=1 for one cycle, then back to IDLE.
- `start` outside IDLE is ignored (no queuing).
- `job_cycles` increments every cycle `busy`=1. It holds its value from IDLE until the next accepted start.
- `sa_rst` = `rst` OR (state==CLEAR).
- **Reset:** state→IDLE; `busy`, `done`, `result_valid`, `rd_en`s, `feed_valid` → 0; `result_data`, `job_cycles`, latched base/len → 0; `sa_top`/`sa_left` → 0; `sa_rst`=1 while `rst`=1.
- **Reset mid-job:** abandons the job immediately. No `done` pulse and no `result_valid`.

## Timing
- Edge E0 samples `start`. CLEAR is cycle 1, FEED is cycles 2..K+1, DRAIN is cycles K+2..K+1+D (D=DRAIN_CYCLES).
- `result_valid` is first high in cycle K+2+D.
- With `result_ready` already high, `done` is in cycle K+3+D.
- `job_cycles` = K+3+D plus any backpressure cycles.
- Operand n reaches the array in cycle n+3.
- When `result_ready` is high on the first OUTPUT cycle, the handshake takes 1 cycle.
- `vec_len`=0: `done` in cycle 1, `job_cycles`=1.

## Test plan
- **Basic job.** NUM_ROW=8, K=4, D=16, act word n = row+n, wgt = 1, `result_ready` tied 1 → `act_rd_addr` 0..3 in cycles 2..5; `result_valid` in cycle 22; `done` in cycle 23; `job_cycles`=23; `result_data` equals `sa_result` from cycle 21.
- **Backpressure.** Hold `result_ready`=0 for 5 cycles in OUTPUT → `result_valid` and `result_data` stable for all 5 cycles; `done` 1 cycle after ready rises; `job_cycles`=28.
- **Start while busy and back-to-back jobs.** Pulse `start` in cycles 3 and 10 of a job → ignored. A start in the cycle after `done` → accepted, with `sa_rst` pulsed in its CLEAR cycle.
- **Address wrap.** `base_addr`=1022, K=4, ADDR_WIDTH=10 → addresses 1022, 1023, 0, 1.
- **Zero length.** `vec_len`=0 → `done` in cycle 1; no `rd_en`; no `sa_rst` pulse; `result_valid` stays 0.
- **Reset mid-FEED.** Assert `rst` in FEED cycle 3 → next cycle IDLE; `busy`=0; `sa_rst`=1 during reset; no `done`; the next job runs normally.
